// File: rtl/hfs_pkg.sv
// Shared select-code map, header payload structs and segment-length helper
// for the header feature selector.
package hfs_pkg;

  localparam int unsigned FIELD_W   = 16;
  localparam int unsigned SEG_LEN_W = 17;

  localparam int unsigned SEL_ID       = 0;
  localparam int unsigned SEL_DF_FRAG  = 1;
  localparam int unsigned SEL_TOT_LEN  = 2;
  localparam int unsigned SEL_TOS      = 3;
  localparam int unsigned SEL_SEG_LEN  = 4;
  localparam int unsigned SEL_DOFF4    = 5;
  localparam int unsigned SEL_FIN      = 6;
  localparam int unsigned SEL_SYN      = 7;
  localparam int unsigned SEL_RST      = 8;
  localparam int unsigned SEL_ID_ALT   = 9;
  localparam int unsigned SEL_ACK      = 10;
  localparam int unsigned SEL_FLAGS    = 11;
  localparam int unsigned SEL_IHL4     = 12;
  localparam int unsigned SEL_WINDOW   = 13;

  // Raw header fields as captured by the first pipeline stage
  typedef struct packed {
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [15:0] window;
    logic [7:0]  tos;
    logic [12:0] frag_off;
    logic [3:0]  ihl;
    logic [3:0]  doff;
    logic        df;
    logic        ack;
    logic        rst;
    logic        syn;
    logic        fin;
  } hfs_hdr_t;

  // Everything a lane mux can pick from, derived values included
  typedef struct packed {
    logic [15:0]          tot_len;
    logic [15:0]          id;
    logic [15:0]          window;
    logic [7:0]           tos;
    logic [12:0]          frag_off;
    logic                 df;
    logic                 ack;
    logic                 rst;
    logic                 syn;
    logic                 fin;
    logic [5:0]           ihl4;
    logic [5:0]           doff4;
    logic [SEG_LEN_W-1:0] seg_len;
  } hfs_src_t;

  // Payload length; MSB set means the header lengths exceed tot_len
  function automatic logic [SEG_LEN_W-1:0] calc_seg_len(
    input logic [15:0] tot_len,
    input logic [5:0]  ihl4,
    input logic [5:0]  doff4
  );
    return SEG_LEN_W'(tot_len) - SEG_LEN_W'(ihl4) - SEG_LEN_W'(doff4);
  endfunction

endpackage

// File: rtl/hfs_lane_mux.sv
// Combinational per-lane select: maps a node-select code to a zero-extended
// feature and flags unsupported codes or a negative segment length.
module hfs_lane_mux
  import hfs_pkg::*;
#(
  parameter int unsigned FEAT_W = 16,
  parameter int unsigned SEL_W  = 4
) (
  input  hfs_src_t           i_src,
  input  logic [SEL_W-1:0]   i_sel,
  output logic [FEAT_W-1:0]  o_feat_c,
  output logic               o_err_c
);

  logic [FIELD_W-1:0] w_feat;
  logic               w_err;
  logic               w_seg_neg;

  assign w_seg_neg = i_src.seg_len[SEG_LEN_W-1];

  always_comb begin
    w_feat = '0;
    w_err  = 1'b0;
    case (32'(i_sel))
      SEL_ID, SEL_ID_ALT: w_feat = i_src.id;
      SEL_DF_FRAG:        w_feat = FIELD_W'({i_src.df, i_src.frag_off});
      SEL_TOT_LEN:        w_feat = i_src.tot_len;
      SEL_TOS:            w_feat = FIELD_W'(i_src.tos);
      SEL_SEG_LEN: begin
        if (w_seg_neg) w_err  = 1'b1;
        else           w_feat = i_src.seg_len[FIELD_W-1:0];
      end
      SEL_DOFF4:          w_feat = FIELD_W'(i_src.doff4);
      SEL_FIN:            w_feat = FIELD_W'(i_src.fin);
      SEL_SYN:            w_feat = FIELD_W'(i_src.syn);
      SEL_RST:            w_feat = FIELD_W'(i_src.rst);
      SEL_ACK:            w_feat = FIELD_W'(i_src.ack);
      SEL_FLAGS:          w_feat = FIELD_W'({i_src.ack, i_src.rst, i_src.syn, i_src.fin});
      SEL_IHL4:           w_feat = FIELD_W'(i_src.ihl4);
      SEL_WINDOW:         w_feat = i_src.window;
      default:            w_err  = 1'b1;
    endcase
  end

  assign o_feat_c = FEAT_W'(w_feat);
  assign o_err_c  = w_err;

endmodule

// File: rtl/header_feature_sel.sv
// Two-stage elastic pipeline selecting one header-derived feature per lane.
// S1 holds header fields and select codes; S2 holds the muxed feature vector.
module header_feature_sel
  import hfs_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned FEAT_W    = 16,
  parameter int unsigned SEL_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hdr_valid,
  output logic                        hdr_ready,
  input  logic [15:0]                 l3_iph_tot_len,
  input  logic [15:0]                 l3_iph_id,
  input  logic [15:0]                 l4_tcph_window,
  input  logic [3:0]                  l3_iph_ihl,
  input  logic [3:0]                  l4_tcph_doff,
  input  logic [7:0]                  l3_iph_tos,
  input  logic [12:0]                 l3_iph_frag_off,
  input  logic                        l3_iph_df,
  input  logic                        l4_tcph_syn,
  input  logic                        l4_tcph_fin,
  input  logic                        l4_tcph_rst,
  input  logic                        l4_tcph_ack,
  input  logic [NUM_LANES*SEL_W-1:0]  node_sel,
  output logic                        feat_valid,
  input  logic                        feat_ready,
  output logic [NUM_LANES*FEAT_W-1:0] feat_data,
  output logic [NUM_LANES-1:0]        feat_err
);

  localparam int unsigned DATA_W = NUM_LANES * FEAT_W;
  localparam int unsigned SELS_W = NUM_LANES * SEL_W;

  logic                 r_run;
  logic                 r_s1_valid;
  hfs_hdr_t             r_s1_hdr;
  logic [SELS_W-1:0]    r_s1_sel;
  logic                 r_s2_valid;
  logic [DATA_W-1:0]    r_feat_data;
  logic [NUM_LANES-1:0] r_feat_err;

  hfs_hdr_t             w_hdr;
  hfs_src_t             w_src;
  logic                 w_s1_ready;
  logic                 w_s2_ready;
  logic                 w_hdr_fire;
  logic                 w_s1_fire;
  logic [DATA_W-1:0]    w_lane_data;
  logic [NUM_LANES-1:0] w_lane_err;

  // A stage accepts when empty or when its contents move on this cycle
  assign w_s2_ready = !r_s2_valid || feat_ready;
  assign w_s1_ready = r_run && (!r_s1_valid || w_s2_ready);
  assign w_hdr_fire = hdr_valid && w_s1_ready;
  assign w_s1_fire  = r_s1_valid && w_s2_ready;

  assign hdr_ready  = w_s1_ready;
  assign feat_valid = r_s2_valid;
  assign feat_data  = r_feat_data;
  assign feat_err   = r_feat_err;

  always_comb begin
    w_hdr          = '0;
    w_hdr.tot_len  = l3_iph_tot_len;
    w_hdr.id       = l3_iph_id;
    w_hdr.window   = l4_tcph_window;
    w_hdr.tos      = l3_iph_tos;
    w_hdr.frag_off = l3_iph_frag_off;
    w_hdr.ihl      = l3_iph_ihl;
    w_hdr.doff     = l4_tcph_doff;
    w_hdr.df       = l3_iph_df;
    w_hdr.ack      = l4_tcph_ack;
    w_hdr.rst      = l4_tcph_rst;
    w_hdr.syn      = l4_tcph_syn;
    w_hdr.fin      = l4_tcph_fin;
  end

  // S1 derived values shared by all lanes
  always_comb begin
    w_src          = '0;
    w_src.tot_len  = r_s1_hdr.tot_len;
    w_src.id       = r_s1_hdr.id;
    w_src.window   = r_s1_hdr.window;
    w_src.tos      = r_s1_hdr.tos;
    w_src.frag_off = r_s1_hdr.frag_off;
    w_src.df       = r_s1_hdr.df;
    w_src.ack      = r_s1_hdr.ack;
    w_src.rst      = r_s1_hdr.rst;
    w_src.syn      = r_s1_hdr.syn;
    w_src.fin      = r_s1_hdr.fin;
    w_src.ihl4     = {r_s1_hdr.ihl, 2'b00};
    w_src.doff4    = {r_s1_hdr.doff, 2'b00};
    w_src.seg_len  = calc_seg_len(r_s1_hdr.tot_len, {r_s1_hdr.ihl, 2'b00},
                                  {r_s1_hdr.doff, 2'b00});
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    hfs_lane_mux #(
      .FEAT_W (FEAT_W),
      .SEL_W  (SEL_W)
    ) u_lane_mux (
      .i_src    (w_src),
      .i_sel    (r_s1_sel[k*SEL_W +: SEL_W]),
      .o_feat_c (w_lane_data[k*FEAT_W +: FEAT_W]),
      .o_err_c  (w_lane_err[k])
    );
  end

  // Stage 1: capture header; r_run holds ready low until the first edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_hdr   <= '0;
      r_s1_sel   <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_s1_ready) r_s1_valid <= hdr_valid;
      if (w_hdr_fire) begin
        r_s1_hdr <= w_hdr;
        r_s1_sel <= node_sel;
      end
    end
  end

  // Stage 2: registered feature vector, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_feat_data <= '0;
      r_feat_err  <= '0;
    end else begin
      if (w_s2_ready) r_s2_valid <= r_s1_valid;
      if (w_s1_fire) begin
        r_feat_data <= w_lane_data;
        r_feat_err  <= w_lane_err;
      end
    end
  end

endmodule
